// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the data-memory access path: RV32I load/store funct3
// codes (also used by the downstream load formatter), the sequencer state
// encoding and the datapath widths.
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    localparam int XLEN  = 32;
    localparam int F3W   = 3;
    localparam int CNTW  = 8;
    localparam int BEW   = XLEN / 8;

    // Load funct3
    localparam logic [F3W-1:0] F3_LB  = 3'b000;
    localparam logic [F3W-1:0] F3_LH  = 3'b001;
    localparam logic [F3W-1:0] F3_LW  = 3'b010;
    localparam logic [F3W-1:0] F3_LBU = 3'b100;
    localparam logic [F3W-1:0] F3_LHU = 3'b101;

    // Store funct3
    localparam logic [F3W-1:0] F3_SB  = 3'b000;
    localparam logic [F3W-1:0] F3_SH  = 3'b001;
    localparam logic [F3W-1:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Halfwords need addr[0]==0, words need addr[1:0]==0. Byte accesses and
    // the unsupported width codes never fault.
    function automatic logic is_misaligned(input logic [1:0] f3_lo,
                                           input logic [1:0] addr_lo);
        return ((f3_lo == 2'b01) && addr_lo[0]) ||
               ((f3_lo == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Combinational lane steering for the data bus.
//   i_write     1 = store, 0 = load
//   i_funct3    access width code
//   i_addr_lo   byte offset within the word
//   i_wdata     right-justified store data
//   o_byte_en   lane enables (all lanes for loads)
//   o_wdata     store data replicated across every lane it may land in
// -----------------------------------------------------------------------------
module store_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic             i_write,
    input  logic [F3W-1:0]   i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic [XLEN-1:0]  i_wdata,
    output logic [BEW-1:0]   o_byte_en,
    output logic [XLEN-1:0]  o_wdata
);

    always_comb begin
        o_byte_en = 4'b1111;
        o_wdata   = i_wdata;
        if (i_write) begin
            case (i_funct3)
                F3_SB: begin
                    o_byte_en = 4'b0001 << i_addr_lo;
                    o_wdata   = {4{i_wdata[7:0]}};
                end
                F3_SH: begin
                    o_byte_en = 4'b0011 << i_addr_lo;
                    o_wdata   = {2{i_wdata[15:0]}};
                end
                // SW and unsupported codes behave as a full word.
                default: begin
                    o_byte_en = 4'b1111;
                    o_wdata   = i_wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Sequences one pipeline load/store onto the word-addressed data bus and hands
// the raw read word, byte offset and funct3 to the load formatter.
//   Pipeline side : iReq/iWrite/iFunct3/iAddress/iWriteData in,
//                   oDone/oStall/oMisaligned/oBusError out.
//   Formatter side: oAlignment, oFunct3, oRawData (registered).
//   Bus side      : oBusReq/oBusWe/oBusAddr/oBusByteEn/oBusWData out,
//                   iBusGnt/iBusRValid/iBusRData in.
//   Debug         : oDbgState exposes the sequencer state.
//
// Bus handshake: the request is presented while oBusReq=1 with address,
// write enable, byte enables and write data held constant; the transfer is
// accepted in the cycle iBusGnt=1. For loads the read word is taken in the
// first later cycle with iBusRValid=1. iBusRValid outside that window is
// ignored.
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iReq,
    input  logic             iWrite,
    input  logic [F3W-1:0]   iFunct3,
    input  logic [XLEN-1:0]  iAddress,
    input  logic [XLEN-1:0]  iWriteData,
    output logic             oDone,
    output logic             oStall,
    output logic             oMisaligned,
    output logic             oBusError,
    output logic [1:0]       oAlignment,
    output logic [F3W-1:0]   oFunct3,
    output logic [XLEN-1:0]  oRawData,
    output logic             oBusReq,
    output logic             oBusWe,
    output logic [XLEN-1:0]  oBusAddr,
    output logic [BEW-1:0]   oBusByteEn,
    output logic [XLEN-1:0]  oBusWData,
    input  logic             iBusGnt,
    input  logic             iBusRValid,
    input  logic [XLEN-1:0]  iBusRData,
    output logic [1:0]       oDbgState
);

    state_t            r_state;
    state_t            w_next;

    logic              r_write;
    logic [F3W-1:0]    r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_misaligned;
    logic              r_error;
    logic [XLEN-1:0]   r_raw;
    logic [CNTW-1:0]   r_cnt;

    logic              w_misaligned;
    logic [CNTW:0]     w_cnt_inc;
    logic              w_expire;
    logic              w_in_req;
    logic [BEW-1:0]    w_byte_en;
    logic [XLEN-1:0]   w_lane_wdata;

    assign w_misaligned = is_misaligned(iFunct3[1:0], iAddress[1:0]);

    // The counter holds the number of REQ/RDATA cycles already spent, so the
    // current cycle is the last allowed one when count+1 reaches the limit.
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_expire  = (w_cnt_inc >= 9'(TIMEOUT_CYCLES));

    // ---------------- state register ----------------
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iReq) begin
                    w_next = w_misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                // A grant in the expiry cycle still completes the transfer.
                if (iBusGnt) begin
                    w_next = r_write ? S_RESP : S_RDATA;
                end else if (w_expire) begin
                    w_next = S_RESP;
                end
            end
            S_RDATA: begin
                if (iBusRValid || w_expire) begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- request / result registers ----------------
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_write      <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_misaligned <= 1'b0;
            r_error      <= 1'b0;
            r_raw        <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iReq) begin
                        r_write      <= iWrite;
                        r_funct3     <= iFunct3;
                        r_addr       <= iAddress;
                        r_wdata      <= iWriteData;
                        r_misaligned <= w_misaligned;
                        r_error      <= 1'b0;
                        r_cnt        <= '0;
                        if (w_misaligned) begin
                            r_raw <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (!iBusGnt && w_expire) begin
                        r_error <= 1'b1;
                        r_raw   <= '0;
                    end
                end
                S_RDATA: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (iBusRValid) begin
                        r_raw <= iBusRData;
                    end else if (w_expire) begin
                        r_error <= 1'b1;
                        r_raw   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- lane steering on the registered request ----------------
    store_lane_align u_lane (
        .i_write   (r_write),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .o_byte_en (w_byte_en),
        .o_wdata   (w_lane_wdata)
    );

    // ---------------- outputs ----------------
    // Bus outputs are only driven during REQ so the bus sees zeros otherwise,
    // including immediately on an asynchronous reset.
    assign w_in_req    = (r_state == S_REQ);
    assign oBusReq     = w_in_req;
    assign oBusWe      = w_in_req & r_write;
    assign oBusAddr    = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign oBusByteEn  = w_in_req ? w_byte_en    : '0;
    assign oBusWData   = w_in_req ? w_lane_wdata : '0;

    assign oDone       = (r_state == S_RESP);
    assign oStall      = iReq & ~oDone;
    assign oMisaligned = r_misaligned;
    assign oBusError   = r_error;
    assign oAlignment  = r_addr[1:0];
    assign oFunct3     = r_funct3;
    assign oRawData    = r_raw;
    assign oDbgState   = r_state;

endmodule
